// File: rtl/vertex_transform_engine_if.sv
// Vertex transform engine bus: matrix load, vertex in, result out.
// Master drives matrix/vertex/out_ready; slave is the engine.
interface vertex_transform_engine_if #(
    parameter int WII = 8,
    parameter int WIF = 8,
    parameter int WOI = 8,
    parameter int WOF = 8
);
    localparam int WI = WII + WIF;
    localparam int WO = WOI + WOF;

    logic                  mat_load;
    logic [15:0][WI-1:0]   mat_in;
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0][WI-1:0]    in_vec;
    logic                  out_valid;
    logic                  out_ready;
    logic [3:0][WO-1:0]    out_vec;
    logic                  out_ovf;

    modport master (
        output mat_load, mat_in, in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_vec, out_ovf
    );

    modport slave (
        input  mat_load, mat_in, in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_vec, out_ovf
    );
endinterface

// File: rtl/vertex_transform_engine.sv
// Sequential MVP vertex transform, one matrix row per clock.
// Optional sticky overflow flag: define VTE_OVF_STICKY_EN.
module vertex_transform_engine #(
    parameter int WII = 8,
    parameter int WIF = 8,
    parameter int WOI = 8,
    parameter int WOF = 8
) (
    input  logic clk_i,
    input  logic rst_i,
`ifdef VTE_OVF_STICKY_EN
    output logic ovf_sticky_o,
`endif
    vertex_transform_engine_if.slave bus
);
    localparam int WI  = WII + WIF;
    localparam int WO  = WOI + WOF;
    localparam int AW  = 2 * WI + 2;
    localparam int SH  = 2 * WIF - WOF;
    localparam int RSH = (SH > 0) ? SH : 0;
    localparam int LSH = (SH < 0) ? -SH : 0;
    localparam int RW  = AW + 1 + LSH;

    localparam logic signed [RW-1:0] OMAX =
        {{(RW-WO+1){1'b0}}, {(WO-1){1'b1}}};
    localparam logic signed [RW-1:0] OMIN =
        {{(RW-WO+1){1'b1}}, {(WO-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          row_q;
    logic [15:0][WI-1:0] mat_q;
    logic [3:0][WI-1:0]  vec_q;
    logic [3:0][WO-1:0]  out_q;
    logic [3:0]          sat_q;

    logic                in_ready, out_valid;
    logic                mat_take, vec_take, hs;

    logic [3:0]          idx;
    logic [2*WI-1:0]     ma, va, prod;
    logic signed [AW-1:0] acc;
    logic signed [RW-1:0] ext, scaled;
    logic [WO-1:0]       row_res;
    logic                row_sat;

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mat_take  = 1'b0;
        vec_take  = 1'b0;
        hs        = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                mat_take = bus.mat_load;
                if (bus.in_valid) begin
                    vec_take = 1'b1;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (row_q == 2'd3) state_d = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    hs      = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Dot product of the current matrix row with the held vertex
    always_comb begin
        acc  = '0;
        idx  = '0;
        ma   = '0;
        va   = '0;
        prod = '0;
        for (int c = 0; c < 4; c++) begin
            idx  = {row_q, 2'(c)};
            ma   = {{WI{mat_q[idx][WI-1]}}, mat_q[idx]};
            va   = {{WI{vec_q[c][WI-1]}}, vec_q[c]};
            prod = ma * va;
            acc  = acc + {{2{prod[2*WI-1]}}, prod};
        end
    end

    assign ext = {{(RW-AW){acc[AW-1]}}, acc};

    generate
        if (RSH > 0) begin : g_rshift
            localparam logic signed [RW-1:0] RND = RW'(1) << (RSH - 1);
            assign scaled = (ext + RND) >>> RSH;
        end else begin : g_lshift
            assign scaled = ext <<< LSH;
        end
    endgenerate

    // Clamp the rescaled row to the signed output range
    always_comb begin
        row_res = scaled[WO-1:0];
        row_sat = 1'b0;
        if (scaled > OMAX) begin
            row_res = {1'b0, {(WO-1){1'b1}}};
            row_sat = 1'b1;
        end else if (scaled < OMIN) begin
            row_res = {1'b1, {(WO-1){1'b0}}};
            row_sat = 1'b1;
        end
    end

    // Matrix/vertex capture and per-row result registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mat_q <= '0;
            vec_q <= '0;
            out_q <= '0;
            sat_q <= '0;
            row_q <= '0;
        end else begin
            if (mat_take) mat_q <= bus.mat_in;
            if (vec_take) begin
                vec_q <= bus.in_vec;
                row_q <= '0;
            end
            if (state_q == S_BUSY) begin
                out_q[row_q] <= row_res;
                sat_q[row_q] <= row_sat;
                row_q        <= row_q + 2'd1;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_vec   = out_q;
    assign bus.out_ovf   = |sat_q;

`ifdef VTE_OVF_STICKY_EN
    logic sticky_q;

    // Sticky overflow: set on an overflowing handshake, cleared by load
    always_ff @(posedge clk_i) begin
        if (rst_i)                    sticky_q <= 1'b0;
        else if (mat_take)            sticky_q <= 1'b0;
        else if (hs && bus.out_ovf)   sticky_q <= 1'b1;
    end

    assign ovf_sticky_o = sticky_q;
`endif
endmodule

// File: tb/tb_vertex_transform_engine.sv
// Directed bench for vertex_transform_engine (Q8.8 defaults).
// Scoreboard queue of expected vertices, immediate-assert checks.
module tb_vertex_transform_engine;
    typedef logic [15:0][15:0] mat_t;
    typedef logic [3:0][15:0]  vec_t;
    typedef struct packed {
        logic [63:0] v;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vertex_transform_engine_if bus ();

`ifdef VTE_OVF_STICKY_EN
    logic sticky;
`endif

    vertex_transform_engine dut (
        .clk_i        (clk),
        .rst_i        (rst),
`ifdef VTE_OVF_STICKY_EN
        .ovf_sticky_o (sticky),
`endif
        .bus          (bus)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(input logic [15:0] x, input logic [15:0] y,
                                 input logic [15:0] z, input logic [15:0] w);
        return {w, z, y, x};
    endfunction

    function automatic mat_t ident(input logic [15:0] d);
        mat_t m;
        m = '0;
        for (int i = 0; i < 4; i++) m[5*i] = d;
        return m;
    endfunction

    // Independent Q8.8 reference: exact integer sum, round half up, clamp
    task automatic model(input mat_t m, input vec_t v,
                         output logic [63:0] o, output logic ov);
        longint s;
        ov = 1'b0;
        o  = '0;
        for (int r = 0; r < 4; r++) begin
            s = 0;
            for (int c = 0; c < 4; c++)
                s += longint'($signed(m[4*r+c])) * longint'($signed(v[c]));
            s = (s + 128) >>> 8;
            if (s > 32767) begin
                s = 32767; ov = 1'b1;
            end else if (s < -32768) begin
                s = -32768; ov = 1'b1;
            end
            o[16*r +: 16] = s[15:0];
        end
    endtask

    task automatic send(input vec_t v, input logic [63:0] ev, input logic eo,
                        input logic ld, input mat_t m);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            step();
            n++;
        end
        check("in_ready_wait", 64'(bus.in_ready), 64'd1);
        bus.in_vec   = v;
        bus.in_valid = 1'b1;
        if (ld) begin
            bus.mat_in   = m;
            bus.mat_load = 1'b1;
        end
        sb.push_back('{v: ev, ovf: eo});
        step();
        bus.in_valid = 1'b0;
        bus.mat_load = 1'b0;
    endtask

    task automatic recv(input string tag, input int exp_lat);
        int   n;
        exp_t e;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        if (exp_lat >= 0) check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_vec"}, bus.out_vec, e.v);
            check({tag, "_ovf"}, 64'(bus.out_ovf), 64'(e.ovf));
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, "_back_idle"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_valid_low"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        mat_t        m;
        vec_t        v;
        logic [63:0] ev;
        logic        eo;
        logic [63:0] held;

        bus.mat_load  = 1'b0;
        bus.mat_in    = '0;
        bus.in_valid  = 1'b0;
        bus.in_vec    = '0;
        bus.out_ready = 1'b0;

        // Reset state
        step();
        step();
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_vec", bus.out_vec, 64'd0);
        check("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
`ifdef VTE_OVF_STICKY_EN
        check("rst_sticky", 64'(sticky), 64'd0);
`endif
        rst = 1'b0;

        // Identity with latency check
        v = mkv(16'h0200, 16'hFF00, 16'h0080, 16'h0100);
        send(v, v, 1'b0, 1'b1, ident(16'h0100));
        recv("ident", 4);

        // Translation
        m = ident(16'h0100);
        m[3] = 16'h0300;
        m[7] = 16'hFE00;
        send(mkv(16'h0100, 16'h0100, 16'h0000, 16'h0100),
             mkv(16'h0400, 16'hFF00, 16'h0000, 16'h0100), 1'b0, 1'b1, m);
        recv("xlate", -1);

        // Positive and negative saturation
        m = '0;
        m[0] = 16'h7F00;
        send(mkv(16'h0200, 16'h0, 16'h0, 16'h0),
             mkv(16'h7FFF, 16'h0, 16'h0, 16'h0), 1'b1, 1'b1, m);
        recv("sat_pos", -1);
`ifdef VTE_OVF_STICKY_EN
        check("sticky_set", 64'(sticky), 64'd1);
`endif
        send(mkv(16'hFE00, 16'h0, 16'h0, 16'h0),
             mkv(16'h8000, 16'h0, 16'h0, 16'h0), 1'b1, 1'b0, m);
        recv("sat_neg", -1);
        send(mkv(16'h0001, 16'h0, 16'h0, 16'h0),
             mkv(16'h007F, 16'h0, 16'h0, 16'h0), 1'b0, 1'b0, m);
        recv("no_sat", -1);
`ifdef VTE_OVF_STICKY_EN
        check("sticky_hold", 64'(sticky), 64'd1);
`endif

        // Rounding ties toward +inf
        m = '0;
        m[0] = 16'h0080;
        send(mkv(16'h0001, 16'h0, 16'h0, 16'h0),
             mkv(16'h0001, 16'h0, 16'h0, 16'h0), 1'b0, 1'b1, m);
        recv("rnd_pos", -1);
`ifdef VTE_OVF_STICKY_EN
        check("sticky_clr", 64'(sticky), 64'd0);
`endif
        send(mkv(16'hFFFF, 16'h0, 16'h0, 16'h0),
             mkv(16'h0000, 16'h0, 16'h0, 16'h0), 1'b0, 1'b0, m);
        recv("rnd_neg", -1);

        // Random matrices and vertices against the reference model
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 16; i++)
                m[i] = (k < 2) ? 16'($urandom)
                               : 16'($urandom_range(0, 16'h0400)) - 16'h0200;
            for (int i = 0; i < 4; i++)
                v[i] = (k < 2) ? 16'($urandom)
                               : 16'($urandom_range(0, 16'h0800)) - 16'h0400;
            model(m, v, ev, eo);
            send(v, ev, eo, 1'b1, m);
            recv("rand", 4);
        end

        // Backpressure: results held, mat_load ignored in DONE
        m = ident(16'h0100);
        v = mkv(16'h0300, 16'h0100, 16'hFD00, 16'h0100);
        send(v, v, 1'b0, 1'b1, m);
        while (!bus.out_valid && total < 100000) step();
        held = bus.out_vec;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                bus.mat_in   = ident(16'h0300);
                bus.mat_load = 1'b1;
            end
            step();
            bus.mat_load = 1'b0;
            check("bp_valid", 64'(bus.out_valid), 64'd1);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_vec", bus.out_vec, held);
        end
        recv("bp", -1);
        v = mkv(16'h0100, 16'h0200, 16'h0300, 16'h0100);
        send(v, v, 1'b0, 1'b0, m);
        recv("bp_after", -1);

        // Simultaneous matrix load and vertex accept
        send(mkv(16'h0100, 16'h0, 16'h0, 16'h0100),
             mkv(16'h0200, 16'h0, 16'h0, 16'h0200), 1'b0, 1'b1,
             ident(16'h0200));
        recv("simul", 4);

        // Reset in the middle of BUSY after two rows
        bus.in_vec   = mkv(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_vec", bus.out_vec, 64'd0);
        check("mid_rst_ovf", 64'(bus.out_ovf), 64'd0);
        send(mkv(16'h0100, 16'h0100, 16'h0100, 16'h0100),
             64'd0, 1'b0, 1'b0, '0);
        recv("mat_cleared", 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
